// File: rtl/dump_pkg.sv
// Shared types and constants for the channel-dump sequencer.
package dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OFF_CMD,
    ST_OFF_RD,
    ST_GAIN_CMD,
    ST_GAIN_RD,
    ST_RD,
    ST_TX,
    ST_TX_WAIT,
    ST_DONE
  } dump_state_t;

  localparam logic [15:0] EEP_RD_DUMMY = 16'hBCBC;
  localparam logic [2:0]  SS_EEP       = 3'b100;

  // EEPROM calibration byte address: sel=0 offset, sel=1 gain.
  function automatic logic [5:0] cal_addr(input logic [1:0] ch, input logic [2:0] g,
                                          input logic sel);
    return {ch, g, sel};
  endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// SPI master-side handshake shared between dump_ctrl and the SPI master.
interface dump_ctrl_if;

  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        SPI_done;

  modport master (output wrt_SPI, SPI_data, ss, input SPI_done);
  modport slave  (input wrt_SPI, SPI_data, ss, output SPI_done);

endinterface

// File: rtl/dump_addr_gen.sv
// Capture-RAM read pointer (wraps at ENTRIES) plus per-dump sample counter.
module dump_addr_gen #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_start,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_ptr <= i_start;
      r_cnt <= '0;
    end else if (i_adv) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_ptr  = r_ptr;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/dump_ctrl.sv
// Channel-dump sequencer: EEPROM calibration fetch, then capture-RAM walk to UART.
// Optional DUMP_CAL_CACHE_EN skips the EEPROM fetch when {ch, gain} is already loaded.
module dump_ctrl
  import dump_pkg::*;
#(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump,
  input  logic [1:0]        dump_ch,
  input  logic [2:0]        ch1_AFEgain,
  input  logic [2:0]        ch2_AFEgain,
  input  logic [2:0]        ch3_AFEgain,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic              eep_wr,
  input  logic              resp_sent,
  dump_ctrl_if.master       spi,
  output logic              flopOffset,
  output logic              flopGain,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              send_resp,
  output logic              busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  dump_state_t       r_state, w_next;
  logic              r_new;
  logic [1:0]        r_ch;
  logic [2:0]        r_g;
  logic [2:0]        w_g;
  logic              w_accept, w_hit, w_adv, w_last, w_wrt;
  logic [ADDR_W-1:0] w_start, w_ptr;
  logic [15:0]       w_spi_data;
  logic [2:0]        w_ss;

  always_comb begin
    case (dump_ch)
      2'b00:   w_g = ch1_AFEgain;
      2'b01:   w_g = ch2_AFEgain;
      2'b10:   w_g = ch3_AFEgain;
      default: w_g = '0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && dump && (dump_ch != 2'b11);
  assign w_start  = (trace_end == LAST) ? '0 : trace_end + 1'b1;

`ifdef DUMP_CAL_CACHE_EN
  logic       r_valid;
  logic [4:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (eep_wr) begin
      r_valid <= 1'b0;
    end else if (flopGain) begin
      r_valid <= 1'b1;
      r_tag   <= {r_ch, r_g};
    end
  end

  assign w_hit = r_valid && (r_tag == {dump_ch, w_g});
`else
  logic w_unused_eep_wr;
  assign w_unused_eep_wr = eep_wr;
  assign w_hit           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_new   <= 1'b0;
      r_ch    <= '0;
      r_g     <= '0;
    end else begin
      r_state <= w_next;
      // Marks the first cycle of every state; qualifies the single-cycle wrt_SPI.
      r_new   <= (w_next != r_state);
      if (w_accept) begin
        r_ch <= dump_ch;
        r_g  <= w_g;
      end
    end
  end

  dump_addr_gen #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_start(w_start),
    .i_adv  (w_adv),
    .o_ptr  (w_ptr),
    .o_last (w_last)
  );

  always_comb begin
    w_next     = r_state;
    w_adv      = 1'b0;
    w_wrt      = 1'b0;
    w_spi_data = '0;
    w_ss       = '0;
    flopOffset = 1'b0;
    flopGain   = 1'b0;
    ren        = 1'b0;
    raddr      = '0;
    send_resp  = 1'b0;
    dump_done  = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_hit ? ST_RD : ST_OFF_CMD;
      ST_OFF_CMD: begin
        w_wrt      = r_new;
        w_ss       = SS_EEP;
        w_spi_data = {2'b00, cal_addr(r_ch, r_g, 1'b0), 8'h00};
        if (spi.SPI_done) w_next = ST_OFF_RD;
      end
      ST_OFF_RD: begin
        w_wrt      = r_new;
        w_ss       = SS_EEP;
        w_spi_data = EEP_RD_DUMMY;
        if (spi.SPI_done) begin
          flopOffset = 1'b1;
          w_next     = ST_GAIN_CMD;
        end
      end
      ST_GAIN_CMD: begin
        w_wrt      = r_new;
        w_ss       = SS_EEP;
        w_spi_data = {2'b00, cal_addr(r_ch, r_g, 1'b1), 8'h00};
        if (spi.SPI_done) w_next = ST_GAIN_RD;
      end
      ST_GAIN_RD: begin
        w_wrt      = r_new;
        w_ss       = SS_EEP;
        w_spi_data = EEP_RD_DUMMY;
        if (spi.SPI_done) begin
          flopGain = 1'b1;
          w_next   = ST_RD;
        end
      end
      ST_RD: begin
        ren    = 1'b1;
        raddr  = w_ptr;
        w_next = ST_TX;
      end
      ST_TX: begin
        send_resp = 1'b1;
        raddr     = w_ptr;
        w_next    = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        raddr = w_ptr;
        if (resp_sent) begin
          if (w_last) begin
            w_next = ST_DONE;
          end else begin
            w_adv  = 1'b1;
            w_next = ST_RD;
          end
        end
      end
      ST_DONE: begin
        dump_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign spi.wrt_SPI  = w_wrt;
  assign spi.SPI_data = w_spi_data;
  assign spi.ss       = w_ss;

endmodule

// File: tb/tb_dump_ctrl.sv
// Bench for dump_ctrl: event-level model of the dump sequence plus directed scenarios.
module tb_dump_ctrl;

  localparam int ENT = 384;
  localparam int AW  = 9;
`ifdef DUMP_CAL_CACHE_EN
  localparam int HIT_SPI = 0;
`else
  localparam int HIT_SPI = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dump = 1'b0;
  logic [1:0]    dump_ch = '0;
  logic [2:0]    g1 = '0, g2 = '0, g3 = '0;
  logic [AW-1:0] trace_end = '0;
  logic          eep_wr = 1'b0;
  logic          resp_sent = 1'b0;
  logic          flopOffset, flopGain, ren, send_resp, busy, dump_done;
  logic [AW-1:0] raddr;

  dump_ctrl_if spi ();

  dump_ctrl #(.ENTRIES(ENT), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump       (dump),
    .dump_ch    (dump_ch),
    .ch1_AFEgain(g1),
    .ch2_AFEgain(g2),
    .ch3_AFEgain(g3),
    .trace_end  (trace_end),
    .eep_wr     (eep_wr),
    .resp_sent  (resp_sent),
    .spi        (spi),
    .flopOffset (flopOffset),
    .flopGain   (flopGain),
    .ren        (ren),
    .raddr      (raddr),
    .send_resp  (send_resp),
    .busy       (busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Stray-pulse requests from the stimulus process to the responder.
  int stray_spi_req  = 0;
  int stray_resp_req = 0;

  // SPI / UART responder: SPI_done 3 cycles after wrt_SPI, resp_sent 2 cycles after send_resp.
  initial begin
    int spi_cnt, uart_cnt, s_spi, s_resp;
    spi_cnt = 0; uart_cnt = 0; s_spi = 0; s_resp = 0;
    spi.SPI_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      spi.SPI_done = 1'b0;
      resp_sent    = 1'b0;
      if (!rst_n) begin
        spi_cnt  = 0;
        uart_cnt = 0;
      end
      if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) spi.SPI_done = 1'b1;
      end
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) resp_sent = 1'b1;
      end
      if (s_spi != stray_spi_req) begin
        s_spi = stray_spi_req;
        spi.SPI_done = 1'b1;
      end
      if (s_resp != stray_resp_req) begin
        s_resp = stray_resp_req;
        resp_sent = 1'b1;
      end
      if (spi.wrt_SPI) spi_cnt = 3;
      if (send_resp) uart_cnt = 2;
    end
  end

  // Model state (written only by the compare process)
  logic [15:0]   q_spi[$];
  logic [AW-1:0] q_addr[$];
  logic [15:0]   spi_log[$];
  logic          m_busy = 1'b0, m_pending = 1'b0, m_in_wait = 1'b0, m_done_seen = 1'b1;
  logic          prev_ren = 1'b0, prev_resp = 1'b0, m_valid = 1'b0;
  logic [4:0]    m_tag = '0;
  logic [1:0]    m_ch = '0;
  logic [2:0]    m_g = '0;
  logic [15:0]   m_last_word = '0;
  logic [AW-1:0] last_addr = '0, first_addr = '0;
  int            m_spi_n = 0, n_resp_dump = 0;
  int            cnt_wrt = 0, cnt_resp = 0, cnt_done = 0;

  always @(negedge clk) begin
    logic          exp_off, exp_gain, exp_done, busy_now, hit;
    logic [2:0]    g;
    logic [AW-1:0] ea;
    int            start;
    if (!rst_n) begin
      check("reset_outputs",
            {spi.wrt_SPI, spi.SPI_data, spi.ss, flopOffset, flopGain, ren, raddr,
             send_resp, busy, dump_done}, '0);
      q_spi.delete(); q_addr.delete();
      m_busy = 1'b0; m_pending = 1'b0; m_valid = 1'b0; m_in_wait = 1'b0;
      prev_ren = 1'b0; prev_resp = 1'b0; m_done_seen = 1'b1; n_resp_dump = 0;
    end else begin
      busy_now = m_busy;
      exp_off  = spi.SPI_done && m_pending && (m_spi_n == 2);
      exp_gain = spi.SPI_done && m_pending && (m_spi_n == 4);
      exp_done = prev_resp && (n_resp_dump == ENT) && !m_done_seen;
      check("busy", busy, m_busy);
      check("flopOffset", flopOffset, exp_off);
      check("flopGain", flopGain, exp_gain);
      check("send_resp_after_ren", send_resp, prev_ren);
      check("dump_done", dump_done, exp_done);
      if (!m_busy) check("idle_quiet", {spi.wrt_SPI, ren}, '0);

      if (spi.wrt_SPI) begin
        cnt_wrt++;
        spi_log.push_back(spi.SPI_data);
        if (q_spi.size() == 0) begin
          check("spi_unexpected", spi.wrt_SPI, 0);
          m_last_word = spi.SPI_data;
        end else begin
          m_last_word = q_spi.pop_front();
          check("spi_word", spi.SPI_data, m_last_word);
        end
        check("spi_ss", spi.ss, 3'b100);
        m_pending = 1'b1;
        m_spi_n++;
      end else if (m_pending) begin
        check("spi_hold", {spi.ss, spi.SPI_data}, {3'b100, m_last_word});
      end
      if (spi.SPI_done && m_pending) begin
        m_pending = 1'b0;
        if (exp_gain) begin
          m_valid = 1'b1;
          m_tag   = {m_ch, m_g};
        end
      end

      if (ren) begin
        if (q_addr.size() == 0) begin
          check("ren_unexpected", ren, 0);
        end else begin
          ea = q_addr.pop_front();
          check("raddr", raddr, ea);
          if (n_resp_dump == 0) first_addr = ea;
          last_addr = ea;
        end
      end
      if (send_resp) begin
        cnt_resp++;
        n_resp_dump++;
        m_in_wait = 1'b1;
        check("raddr_tx", raddr, last_addr);
      end else if (m_in_wait) begin
        check("raddr_hold", raddr, last_addr);
        if (resp_sent) m_in_wait = 1'b0;
      end

      if (dump_done) begin
        cnt_done++;
        m_done_seen = 1'b1;
        m_busy = 1'b0;
        check("spi_left", q_spi.size(), 0);
        check("addr_left", q_addr.size(), 0);
      end
      prev_ren  = ren;
      prev_resp = resp_sent;

      if (dump && !busy_now && dump_ch != 2'b11) begin
        g     = (dump_ch == 2'b00) ? g1 : (dump_ch == 2'b01) ? g2 : g3;
        start = (int'(trace_end) == ENT - 1) ? 0 : int'(trace_end) + 1;
`ifdef DUMP_CAL_CACHE_EN
        hit = m_valid && (m_tag == {dump_ch, g});
`else
        hit = 1'b0;
`endif
        if (!hit) begin
          q_spi.push_back({2'b00, dump_ch, g, 1'b0, 8'h00});
          q_spi.push_back(16'hBCBC);
          q_spi.push_back({2'b00, dump_ch, g, 1'b1, 8'h00});
          q_spi.push_back(16'hBCBC);
        end
        for (int k = 0; k < ENT; k++) q_addr.push_back(AW'((start + k) % ENT));
        m_busy = 1'b1; m_spi_n = 0; m_pending = 1'b0; n_resp_dump = 0;
        m_done_seen = 1'b0; m_in_wait = 1'b0; m_ch = dump_ch; m_g = g;
      end
      if (eep_wr) m_valid = 1'b0;
    end
  end

  task automatic do_dump(input logic [1:0] ch, input logic [AW-1:0] te);
    @(posedge clk); #1;
    dump_ch = ch; trace_end = te; dump = 1'b1;
    @(posedge clk); #1;
    dump = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base_done);
    int n;
    n = 0;
    while (cnt_done == base_done && n < 5000) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, cnt_done - base_done, 1);
  endtask

  initial begin
    int b_w, b_r, b_d, b_s, k, n;
    g1 = 3'b010; g2 = 3'b101; g3 = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_raddr", raddr, 0);
    check("rst_spi_data", spi.SPI_data, 0);
    rst_n = 1'b1;

    // ch2, gain 101, trace_end 100
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done; b_s = spi_log.size();
    do_dump(2'b01, 9'd100);
    wait_done("t1_done", b_d);
    check("t1_nspi", cnt_wrt - b_w, 4);
    check("t1_w0", spi_log[b_s], 16'h1A00);
    check("t1_w1", spi_log[b_s+1], 16'hBCBC);
    check("t1_w2", spi_log[b_s+2], 16'h1B00);
    check("t1_w3", spi_log[b_s+3], 16'hBCBC);
    check("t1_nresp", cnt_resp - b_r, 384);
    check("t1_first", first_addr, 9'd101);
    check("t1_last", last_addr, 9'd100);

    // trace_end at the top of the RAM: walk starts at 0
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done; b_s = spi_log.size();
    do_dump(2'b00, 9'd383);
    wait_done("t2_done", b_d);
    check("t2_nspi", cnt_wrt - b_w, 4);
    check("t2_w0", spi_log[b_s], 16'h0400);
    check("t2_w2", spi_log[b_s+2], 16'h0500);
    check("t2_nresp", cnt_resp - b_r, 384);
    check("t2_first", first_addr, 9'd0);
    check("t2_last", last_addr, 9'd383);

    // reserved channel, then a second dump while busy
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done; b_s = spi_log.size();
    do_dump(2'b11, 9'd50);
    repeat (5) @(posedge clk);
    #1;
    check("t3_ch11_busy", busy, 0);
    check("t3_ch11_spi", cnt_wrt - b_w, 0);
    do_dump(2'b10, 9'd0);
    n = 0;
    while (cnt_resp - b_r < 10 && n < 1000) begin
      @(posedge clk); n++;
    end
    do_dump(2'b01, 9'd5);
    wait_done("t3_done", b_d);
    repeat (20) @(posedge clk);
    #1;
    check("t3_one_done", cnt_done - b_d, 1);
    check("t3_nresp", cnt_resp - b_r, 384);
    check("t3_nspi", cnt_wrt - b_w, 4);
    check("t3_w0", spi_log[b_s], 16'h2E00);
    check("t3_w2", spi_log[b_s+2], 16'h2F00);
    check("t3_first", first_addr, 9'd1);
    check("t3_last", last_addr, 9'd0);

    // stray resp_sent in OFF_CMD, stray SPI_done in TX_WAIT
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done;
    do_dump(2'b00, 9'd383);
    n = 0;
    while (!spi.wrt_SPI && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("t4_wrt_seen", spi.wrt_SPI, 1);
    stray_resp_req++;
    n = 0;
    while (!send_resp && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("t4_tx_seen", send_resp, 1);
    @(posedge clk); #1;
    stray_spi_req++;
    wait_done("t4_done", b_d);
    check("t4_nspi", cnt_wrt - b_w, 4);
    check("t4_nresp", cnt_resp - b_r, 384);

    // reset during TX_WAIT of sample 50
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done;
    do_dump(2'b01, 9'd100);
    k = 0; n = 0;
    while (k < 51 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (send_resp) k++;
    end
    check("t5_reached_50", k, 51);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_raddr", raddr, 0);
    check("t5_rst_send", send_resp, 0);
    check("t5_rst_spi", {spi.wrt_SPI, spi.SPI_data, spi.ss}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", cnt_done - b_d, 0);
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done; b_s = spi_log.size();
    do_dump(2'b01, 9'd100);
    wait_done("t5_restart_done", b_d);
    check("t5_nspi", cnt_wrt - b_w, 4);
    check("t5_w0", spi_log[b_s], 16'h1A00);
    check("t5_nresp", cnt_resp - b_r, 384);

    // identical repeat dump, then again after an EEPROM write
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done;
    do_dump(2'b01, 9'd100);
    wait_done("t6_done", b_d);
    check("t6_nspi", cnt_wrt - b_w, HIT_SPI);
    check("t6_nresp", cnt_resp - b_r, 384);
    check("t6_first", first_addr, 9'd101);
    @(posedge clk); #1; eep_wr = 1'b1;
    @(posedge clk); #1; eep_wr = 1'b0;
    b_w = cnt_wrt; b_r = cnt_resp; b_d = cnt_done;
    do_dump(2'b01, 9'd100);
    wait_done("t7_done", b_d);
    check("t7_nspi", cnt_wrt - b_w, 4);
    check("t7_nresp", cnt_resp - b_r, 384);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_ctrl.md
# dump_ctrl

Sequencer for the scope's channel-dump path. On a dump request it fetches the channel's offset and gain calibration bytes from the calibration EEPROM over the shared SPI master, loads them into the gain-correction registers, then walks the capture RAM from the oldest sample. Each corrected sample goes out through the UART response path. It sits beside the command decoder, which muxes SPI and UART ownership to this block while `busy` is high.

## Interface

Parameters:
- ENTRIES, 384: capture RAM depth in samples.
- ADDR_W, 9: RAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low. Clock is clk.
- dump  in  1  single-cycle dump request.
- dump_ch  in  2  channel (00=CH1, 01=CH2, 10=CH3, 11 reserved).
- ch1_AFEgain, ch2_AFEgain, ch3_AFEgain  in  3 each  current analog gain setting per channel.
- trace_end  in  ADDR_W  address of the newest captured sample.
- eep_wr  in  1  pulse; the command decoder completed an EEPROM write.
- SPI_done  in  1  SPI transaction complete pulse.
- resp_sent  in  1  UART byte transmitted pulse.
- wrt_SPI  out  1  SPI start pulse.
- SPI_data  out  16  SPI word.
- ss  out  3  slave select; always 3'b100 (EEPROM) when driven.
- flopOffset, flopGain  out  1  one-cycle load strobes for the correction registers.
- ren  out  1  RAM read enable.
- raddr  out  ADDR_W  RAM read address.
- send_resp  out  1  UART send pulse; the corrected byte is formed downstream.
- busy  out  1  dump in progress.
- dump_done  out  1  one-cycle completion pulse.

## Operation

**Request acceptance**
- `dump` is accepted only in IDLE with dump_ch != 2'b11.
- A dump while busy, or a dump for channel 11, is ignored: no strobes and no dump_done.
- On accept, latch the channel, that channel's AFEgain (g) and `start = (trace_end == ENTRIES-1) ? 0 : trace_end+1`.

**EEPROM addressing**
- Offset byte: 6-bit address {ch, g, 1'b0}.
- Gain byte: 6-bit address {ch, g, 1'b1}.
- Read transaction: SPI_data = {2'b00, addr6, 8'h00}, followed by a second transaction with SPI_data = 16'hBCBC to clock the data out.

**States**
- IDLE: on accept, go to OFF_CMD.
- OFF_CMD: pulse wrt_SPI with the offset read word. Wait for SPI_done, then go to OFF_RD.
- OFF_RD: pulse wrt_SPI with 16'hBCBC. On SPI_done, pulse flopOffset and go to GAIN_CMD.
- GAIN_CMD: same as OFF_CMD, using the gain address.
- GAIN_RD: same as OFF_RD; on SPI_done, pulse flopGain and go to RD.
- RD: ren=1, raddr=ptr. Go to TX.
- TX: pulse send_resp; raddr held. Go to TX_WAIT.
- TX_WAIT: hold raddr until resp_sent.
  - If count == ENTRIES-1, go to DONE.
  - Otherwise ptr = (ptr == ENTRIES-1) ? 0 : ptr+1, count++, and go to RD.
- DONE: pulse dump_done and go to IDLE.

**Other rules**
- SPI_done or resp_sent arriving in a state that does not wait for it is ignored.
- Exactly ENTRIES bytes are sent per dump. count is ADDR_W bits wide.
- busy is high in every state except IDLE.

## Timing

- Reset: state IDLE. Every output is 0; raddr is 0 and SPI_data is 16'h0000.
- A reset mid-dump aborts immediately with no dump_done.
- wrt_SPI is high for exactly the first cycle of each CMD/RD state. SPI_data and ss are held until the matching SPI_done.
- flopOffset and flopGain assert in the same cycle as the qualifying SPI_done.
- RAM read latency is 1 cycle: data for raddr is valid in TX.
- send_resp goes high one cycle after ren.
- Minimum per-sample period is 3 cycles plus the UART wait.
- dump_done comes 1 cycle after the last resp_sent.

## Configuration

- `DUMP_CAL_CACHE_EN` defined:
  - Keep a valid bit plus the last {ch, g} loaded.
  - If an accepted dump matches and valid=1, go IDLE→RD directly, with no SPI traffic and no load strobes.
  - eep_wr clears valid. valid is 0 at reset.
- Not defined: every dump performs both EEPROM reads. eep_wr is ignored.

## Structure

- Shared package `dump_pkg`: state enum `dump_state_t`, the constant 16'hBCBC (`EEP_RD_DUMMY`), ss code `SS_EEP = 3'b100`, and function `cal_addr(ch, g, sel)`.
- One sub-module, `dump_addr_gen`: the wrapping pointer plus sample counter, with load/advance/last outputs.

## Test plan

- ch=01, ch2_AFEgain=3'b101, trace_end=9'd100 →
  - SPI words 16'h1A00, 16'hBCBC, 16'h1B00, 16'hBCBC.
  - Then raddr sequence 101..383, 0..100.
  - 384 send_resp pulses, then one dump_done.
- trace_end=383 → raddr starts at 0; the last raddr is 383.
- dump with ch=11, and a second dump issued mid-transfer → no SPI, no extra send_resp, one dump_done total for the valid dump.
- rst_n low during TX_WAIT of sample 50 → all outputs 0 in the same cycle. A new dump restarts from the EEPROM reads.
- `DUMP_CAL_CACHE_EN`:
  - Two identical dumps → the second issues zero wrt_SPI.
  - Inserting an eep_wr pulse between them → the second dump issues 4 SPI transactions.
- A stray SPI_done during TX_WAIT and a stray resp_sent during OFF_CMD → no state change and no strobes.
